// File: rtl/dbus_responder_pkg.sv
// Shared types and constants for the data-bus responder.
package dbus_responder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StAck  = 2'd2
  } state_e;

  localparam logic ASSERTED = 1'b0;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/dbus_if.sv
// Processor data-bus signals seen by a bus master (CPU driver) and a slave (responder).
interface dbus_if;

  logic [15:0] ab;
  logic [15:0] db_in;
  logic [15:0] db_out;
  logic        db_oe;
  logic        nmem;
  logic        nio;
  logic        nr;
  logic        nw;
  logic        nws;

  modport master (
    output ab, db_in, nmem, nio, nr, nw,
    input  db_out, db_oe, nws
  );

  modport slave (
    input  ab, db_in, nmem, nio, nr, nw,
    output db_out, db_oe, nws
  );

endinterface

// File: rtl/dbus_wait_counter.sv
// Wait-state down counter: load, decrement to zero and hold, zero flag.
module dbus_wait_counter
  import dbus_responder_pkg::*;
#(
  parameter int unsigned Width = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [Width-1:0] r_cnt;

  assign o_zero = (r_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && !o_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus slave: decodes an address window, inserts wait states, then serves
// reads from / commits the first write of each selection into a small register bank.
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h0010,
  parameter int unsigned REG_AW      = 2,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter bit          IO_SPACE    = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  dbus_if.slave                        bus,
  output logic                         o_wr_strobe,
  output logic [REG_AW-1:0]            o_wr_index,
  output logic [16*(2**REG_AW)-1:0]    o_regs
);

  localparam int unsigned NREG = 2**REG_AW;
  localparam logic [CNT_W-1:0] LOAD_VAL =
      (WAIT_CYCLES != 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  logic [15:0]       r_ab_q, r_db_in_q;
  logic              r_nmem_q, r_nio_q, r_nr_q, r_nw_q;
  state_e            r_state, w_state_d;
  logic [REG_AW-1:0] r_idx, w_idx;
  logic              r_written, r_nws, r_db_oe, r_wr_strobe;
  logic [15:0]       r_db_out;
  logic [REG_AW-1:0] r_wr_index;
  logic [15:0]       r_regs [NREG];
  logic              w_sel, w_space_q, w_cnt_load, w_cnt_dec, w_cnt_zero;
  logic              w_do_write, w_do_read;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ab_q    <= '0;
      r_db_in_q <= '0;
      r_nmem_q  <= ~ASSERTED;
      r_nio_q   <= ~ASSERTED;
      r_nr_q    <= ~ASSERTED;
      r_nw_q    <= ~ASSERTED;
    end else begin
      r_ab_q    <= bus.ab;
      r_db_in_q <= bus.db_in;
      r_nmem_q  <= bus.nmem;
      r_nio_q   <= bus.nio;
      r_nr_q    <= bus.nr;
      r_nw_q    <= bus.nw;
    end
  end

  assign w_space_q = IO_SPACE ? r_nio_q : r_nmem_q;
  assign w_sel     = (w_space_q == ASSERTED) && (r_ab_q[15:REG_AW] == BASE_ADDR[15:REG_AW]);

  dbus_wait_counter #(
    .Width (CNT_W)
  ) u_wait_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    w_state_d  = r_state;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_sel) begin
          if (WAIT_CYCLES != 0) begin
            w_state_d  = StWait;
            w_cnt_load = 1'b1;
          end else begin
            w_state_d = StAck;
          end
        end
      end
      StWait: begin
        if (!w_sel) begin
          w_state_d = StIdle;
        end else if (w_cnt_zero) begin
          w_state_d = StAck;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      StAck: begin
        if (!w_sel) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Index tracks the address until the access starts, then stays frozen until IDLE.
  assign w_idx      = (r_state == StIdle) ? r_ab_q[REG_AW-1:0] : r_idx;
  assign w_do_write = (w_state_d == StAck) && (r_nw_q == ASSERTED) && !r_written;
  assign w_do_read  = (w_state_d == StAck) && (r_nr_q == ASSERTED) && (r_nw_q != ASSERTED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_written   <= 1'b0;
      r_nws       <= ~ASSERTED;
      r_db_oe     <= 1'b0;
      r_db_out    <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_index  <= '0;
      for (int i = 0; i < int'(NREG); i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_state     <= w_state_d;
      r_idx       <= w_idx;
      r_nws       <= (w_state_d == StWait) ? ASSERTED : ~ASSERTED;
      r_db_oe     <= w_do_read;
      r_wr_strobe <= w_do_write;
      if (w_do_read) begin
        r_db_out <= r_regs[w_idx];
      end
      if (w_do_write) begin
        r_regs[w_idx] <= r_db_in_q;
        r_wr_index    <= w_idx;
        r_written     <= 1'b1;
      end else if (w_state_d == StIdle) begin
        r_written <= 1'b0;
      end
    end
  end

  assign bus.nws      = r_nws;
  assign bus.db_oe    = r_db_oe;
  assign bus.db_out   = r_db_out;
  assign o_wr_strobe  = r_wr_strobe;
  assign o_wr_index   = r_wr_index;

  always_comb begin
    o_regs = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      o_regs[16*i +: 16] = r_regs[i];
    end
  end

endmodule

// File: tb/tb_dbus_responder.sv
// Bench: a 2-wait-state and a 0-wait-state responder share one bus stimulus and are
// compared every cycle against a run-length based reference model.
module tb_dbus_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dbus_if bus0 ();
  dbus_if bus1 ();

  assign bus1.ab    = bus0.ab;
  assign bus1.db_in = bus0.db_in;
  assign bus1.nmem  = bus0.nmem;
  assign bus1.nio   = bus0.nio;
  assign bus1.nr    = bus0.nr;
  assign bus1.nw    = bus0.nw;

  logic        stb0, stb1;
  logic [1:0]  widx0, widx1;
  logic [63:0] regs0, regs1;

  dbus_responder #(
    .BASE_ADDR   (16'h0010),
    .REG_AW      (2),
    .WAIT_CYCLES (2),
    .IO_SPACE    (1'b1)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus0),
    .o_wr_strobe (stb0),
    .o_wr_index  (widx0),
    .o_regs      (regs0)
  );

  dbus_responder #(
    .BASE_ADDR   (16'h0010),
    .REG_AW      (2),
    .WAIT_CYCLES (0),
    .IO_SPACE    (1'b1)
  ) u_dut_zw (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus1),
    .o_wr_strobe (stb1),
    .o_wr_index  (widx1),
    .o_regs      (regs1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: an access is a run of consecutive selected samples; after the
  // L-th selected edge the slave waits while L <= wait cycles, then acknowledges.
  logic [15:0] q_ab, q_db;
  logic        q_nio, q_nr, q_nw;
  int          run_len [2];
  logic [1:0]  m_idx [2];
  bit          m_written [2];
  logic [15:0] m_regs [2][4];
  logic        m_nws [2], m_oe [2], m_stb [2];
  logic [15:0] m_out [2];
  logic [1:0]  m_widx [2];

  task automatic model_step();
    bit sel;
    int wc;
    if (reset) begin
      q_ab = '0; q_db = '0; q_nio = 1'b1; q_nr = 1'b1; q_nw = 1'b1;
      for (int d = 0; d < 2; d++) begin
        run_len[d] = 0; m_idx[d] = '0; m_written[d] = 0;
        m_nws[d] = 1'b1; m_oe[d] = 1'b0; m_stb[d] = 1'b0; m_out[d] = '0; m_widx[d] = '0;
        for (int r = 0; r < 4; r++) m_regs[d][r] = '0;
      end
    end else begin
      sel = (q_nio == 1'b0) && (q_ab[15:2] == 14'h0004);
      for (int d = 0; d < 2; d++) begin
        wc = (d == 0) ? 2 : 0;
        if (sel) begin
          if (run_len[d] < 1000) run_len[d]++;
        end else begin
          run_len[d] = 0;
        end
        if (run_len[d] == 1) m_idx[d] = q_ab[1:0];
        m_stb[d] = 1'b0;
        m_nws[d] = !(run_len[d] >= 1 && run_len[d] <= wc);
        if (run_len[d] > wc) begin
          if (!q_nw && !m_written[d]) begin
            m_regs[d][m_idx[d]] = q_db;
            m_stb[d] = 1'b1;
            m_widx[d] = m_idx[d];
            m_written[d] = 1;
          end
          m_oe[d] = !q_nr && q_nw;
          if (m_oe[d]) m_out[d] = m_regs[d][m_idx[d]];
        end else begin
          m_oe[d] = 1'b0;
          if (run_len[d] == 0) m_written[d] = 0;
        end
      end
      q_ab = bus0.ab; q_db = bus0.db_in; q_nio = bus0.nio; q_nr = bus0.nr; q_nw = bus0.nw;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  int         c_stb [2] = '{0, 0};
  int         c_ws [2]  = '{0, 0};
  logic [1:0] last_widx [2] = '{2'd0, 2'd0};

  task automatic check_dut(input int d, input logic nws, input logic oe, input logic [15:0] out,
                           input logic stb, input logic [1:0] widx, input logic [63:0] regs);
    check_eq($sformatf("nws[%0d]", d), nws, m_nws[d]);
    check_eq($sformatf("db_oe[%0d]", d), oe, m_oe[d]);
    check_eq($sformatf("db_out[%0d]", d), out, m_out[d]);
    check_eq($sformatf("wr_strobe[%0d]", d), stb, m_stb[d]);
    if (m_stb[d]) check_eq($sformatf("wr_index[%0d]", d), widx, m_widx[d]);
    check_eq($sformatf("regs[%0d]", d), regs,
             {m_regs[d][3], m_regs[d][2], m_regs[d][1], m_regs[d][0]});
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      check_dut(0, bus0.nws, bus0.db_oe, bus0.db_out, stb0, widx0, regs0);
      check_dut(1, bus1.nws, bus1.db_oe, bus1.db_out, stb1, widx1, regs1);
      c_stb[0] += int'(stb1 ? 0 : 0) + int'(stb0);
      c_stb[1] += int'(stb1);
      c_ws[0]  += int'(!bus0.nws);
      c_ws[1]  += int'(!bus1.nws);
      if (stb0) last_widx[0] = widx0;
      if (stb1) last_widx[1] = widx1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic idle_bus();
    bus0.nio = 1'b1; bus0.nmem = 1'b1; bus0.nr = 1'b1; bus0.nw = 1'b1;
  endtask

  task automatic drive(input logic nio, input logic nmem, input logic [15:0] ab,
                       input logic nr, input logic nw, input logic [15:0] db);
    bus0.nio = nio; bus0.nmem = nmem; bus0.ab = ab; bus0.nr = nr; bus0.nw = nw;
    bus0.db_in = db;
  endtask

  int s0, s1, w0, w1;
  logic [15:0] ab_tab [7] = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h000F,
                              16'h0030};

  initial begin
    drive(1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0000);
    wait_cyc(2);
    check_eq("rst_nws", bus0.nws, 1'b1);
    check_eq("rst_db_oe", bus0.db_oe, 1'b0);
    check_eq("rst_db_out", bus0.db_out, 16'h0000);
    check_eq("rst_wr_strobe", stb0, 1'b0);
    check_eq("rst_wr_index", widx0, 2'd0);
    check_eq("rst_regs", regs0, 64'h0);
    reset = 1'b0;
    wait_cyc(2);

    // IO write of BEEF to register 2
    s0 = c_stb[0]; s1 = c_stb[1]; w0 = c_ws[0]; w1 = c_ws[1];
    drive(1'b0, 1'b1, 16'h0012, 1'b1, 1'b1, 16'h0000);
    wait_cyc(2);
    bus0.nw = 1'b0; bus0.db_in = 16'hBEEF;
    wait_cyc(4);
    bus0.nw = 1'b1;
    wait_cyc(1);
    idle_bus();
    wait_cyc(3);
    check_eq("wr_nws_low_cycles", c_ws[0] - w0, 2);
    check_eq("wr_strobe_count", c_stb[0] - s0, 1);
    check_eq("wr_index", last_widx[0], 2'd2);
    check_eq("wr_reg2", regs0[47:32], 16'hBEEF);
    check_eq("zw_nws_low_cycles", c_ws[1] - w1, 0);
    check_eq("zw_strobe_count", c_stb[1] - s1, 1);

    // Read back register 2
    drive(1'b0, 1'b1, 16'h0012, 1'b0, 1'b1, 16'h0000);
    wait_cyc(6);
    check_eq("rd_db_oe", bus0.db_oe, 1'b1);
    check_eq("rd_db_out", bus0.db_out, 16'hBEEF);
    check_eq("zw_rd_db_out", bus1.db_out, 16'hBEEF);
    idle_bus();
    wait_cyc(1);
    check_eq("rd_oe_hold", bus0.db_oe, 1'b1);
    wait_cyc(1);
    check_eq("rd_oe_release", bus0.db_oe, 1'b0);
    wait_cyc(2);

    // Decode misses: outside window, and memory space on an IO responder
    s0 = c_stb[0]; s1 = c_stb[1]; w0 = c_ws[0];
    drive(1'b0, 1'b1, 16'h0014, 1'b1, 1'b0, 16'hDEAD);
    wait_cyc(6);
    idle_bus();
    wait_cyc(2);
    drive(1'b1, 1'b0, 16'h0012, 1'b0, 1'b0, 16'hDEAD);
    wait_cyc(6);
    idle_bus();
    wait_cyc(2);
    check_eq("miss_strobe", c_stb[0] - s0, 0);
    check_eq("miss_strobe_zw", c_stb[1] - s1, 0);
    check_eq("miss_nws", c_ws[0] - w0, 0);
    check_eq("miss_regs", regs0, 64'h0000_BEEF_0000_0000);

    // Top of window
    drive(1'b0, 1'b1, 16'h0013, 1'b1, 1'b0, 16'h3333);
    wait_cyc(6);
    idle_bus();
    wait_cyc(2);
    check_eq("hit3_reg", regs0[63:48], 16'h3333);
    check_eq("hit3_index", last_widx[0], 2'd3);

    // Abort during WAIT: one selected sample only
    s0 = c_stb[0]; w0 = c_ws[0];
    drive(1'b0, 1'b1, 16'h0011, 1'b1, 1'b0, 16'hAAAA);
    wait_cyc(1);
    idle_bus();
    wait_cyc(3);
    check_eq("abort_strobe", c_stb[0] - s0, 0);
    check_eq("abort_nws", c_ws[0] - w0, 1);
    check_eq("abort_reg1", regs0[31:16], 16'h0000);
    check_eq("abort_zw_reg1", regs1[31:16], 16'hAAAA);

    // Two write pulses in one selection
    s0 = c_stb[0]; s1 = c_stb[1];
    drive(1'b0, 1'b1, 16'h0010, 1'b1, 1'b1, 16'h0000);
    wait_cyc(3);
    bus0.nw = 1'b0; bus0.db_in = 16'h1111;
    wait_cyc(2);
    bus0.nw = 1'b1;
    wait_cyc(2);
    bus0.nw = 1'b0; bus0.db_in = 16'h2222;
    wait_cyc(2);
    idle_bus();
    wait_cyc(3);
    check_eq("dup_reg0", regs0[15:0], 16'h1111);
    check_eq("dup_strobe", c_stb[0] - s0, 1);
    check_eq("dup_strobe_zw", c_stb[1] - s1, 1);

    // Read and write together: write wins, no drive
    s0 = c_stb[0];
    drive(1'b0, 1'b1, 16'h0011, 1'b0, 1'b0, 16'h5A5A);
    wait_cyc(5);
    check_eq("conflict_oe", bus0.db_oe, 1'b0);
    check_eq("conflict_oe_zw", bus1.db_oe, 1'b0);
    wait_cyc(1);
    idle_bus();
    wait_cyc(3);
    check_eq("conflict_reg1", regs0[31:16], 16'h5A5A);
    check_eq("conflict_strobe", c_stb[0] - s0, 1);

    // Zero-wait read drives on the second edge after selection
    drive(1'b0, 1'b1, 16'h0011, 1'b0, 1'b1, 16'h0000);
    wait_cyc(1);
    check_eq("zw_oe_edge1", bus1.db_oe, 1'b0);
    wait_cyc(1);
    check_eq("zw_oe_edge2", bus1.db_oe, 1'b1);
    check_eq("zw_out_edge2", bus1.db_out, 16'h5A5A);
    check_eq("ws_oe_edge2", bus0.db_oe, 1'b0);
    check_eq("ws_nws_edge2", bus0.nws, 1'b0);
    wait_cyc(4);
    idle_bus();
    wait_cyc(3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(4) == 0) bus0.nio = ~bus0.nio;
      if ($urandom_range(5) == 0) bus0.ab = ab_tab[$urandom_range(6)];
      bus0.nmem = ($urandom_range(3) != 0);
      if ($urandom_range(2) == 0) bus0.nr = ~bus0.nr;
      if ($urandom_range(2) == 0) bus0.nw = ~bus0.nw;
      bus0.db_in = 16'($urandom);
      wait_cyc(1);
    end
    idle_bus();
    wait_cyc(3);
    check_eq("zw_nws_never_low", c_ws[1], 0);

    // Reset in the middle of a wait: everything returns at once
    drive(1'b0, 1'b1, 16'h0012, 1'b1, 1'b0, 16'h7777);
    wait_cyc(2);
    check_eq("mid_wait_nws", bus0.nws, 1'b0);
    #1 reset = 1'b1;
    #1;
    check_eq("async_rst_nws", bus0.nws, 1'b1);
    check_eq("async_rst_oe", bus0.db_oe, 1'b0);
    check_eq("async_rst_regs", regs0, 64'h0);
    check_eq("async_rst_strobe", stb0, 1'b0);
    check_eq("async_rst_regs_zw", regs1, 64'h0);
    idle_bus();
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(4);
    check_eq("post_rst_regs", regs0, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dbus_responder.md
Name: dbus_responder

Overview:
- Bus-side responder (slave) for the processor data bus: the far end of the CPU's data bus driver.
- Decodes MEM#/IO# plus address against a base window and holds WS# low for a programmable number of wait states.
- Then sources read data onto the data bus, or captures write data on the W# strobe.
- Contains a small bank of 16-bit registers, exported to the rest of the design; sits on the peripheral side of the backplane.

Parameters:
- BASE_ADDR, 16'h0010, base address of register window; must be aligned to 2**REG_AW.
- REG_AW, 2, register index width; window holds 2**REG_AW registers.
- WAIT_CYCLES, 2, clk cycles WS# is held low per access (0..15).
- IO_SPACE, 1, 1 = decode on nio, 0 = decode on nmem.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ab  input  16  address bus.
- db_in  input  16  data bus, sampled.
- db_out  output  16  read data to data bus.
- db_oe  output  1  data bus drive enable (1 = drive db_out).
- nmem  input  1  memory space select, active low.
- nio  input  1  I/O space select, active low.
- nr  input  1  read strobe, active low.
- nw  input  1  write strobe, active low.
- nws  output  1  wait-state request, active low.
- wr_strobe  output  1  one-cycle pulse when a register is written.
- wr_index  output  REG_AW  index of the register written (valid with wr_strobe).
- regs  output  16*2**REG_AW  flat register contents; reg i at [16*i+15:16*i].

Behaviour:
- Input stage: ab, db_in, nmem, nio, nr and nw are registered once (the _q versions).
  - sel_q = space select low (per IO_SPACE) AND ab_q[15:REG_AW] == BASE_ADDR[15:REG_AW].
- Reset (asynchronous, while reset=1):
  - state=IDLE; nws=1, db_oe=0, db_out=0, wr_strobe=0, wr_index=0.
  - All regs=0; wait counter=0; written flag=0.
- FSM states: IDLE, WAIT, ACK. All outputs are registered.
  - IDLE -> WAIT on sel_q, when WAIT_CYCLES>0. Latch idx=ab_q[REG_AW-1:0] and load cnt=WAIT_CYCLES-1.
  - IDLE -> ACK on sel_q, when WAIT_CYCLES==0. Latch idx.
  - WAIT: nws=0. Decrement cnt; at cnt==0 go to ACK. If sel_q drops, go to IDLE (abort, no write).
  - ACK: nws=1.
    - If nr_q=0 and nw_q=1: db_oe=1, db_out=regs[idx] (refreshed every cycle).
    - If nw_q=0 and the written flag is clear: regs[idx]<=db_in_q; wr_strobe=1 for one cycle; wr_index=idx; set the flag.
    - Stay in ACK while sel_q. On !sel_q go to IDLE: db_oe=0 and the flag is cleared on the same edge.
- Latency: sel at the pins before edge k gives sel_q after edge k. nws falls after edge k+1 and stays low exactly WAIT_CYCLES cycles. The first read drive follows the edge into ACK.
- Boundary conditions:
  - nr_q and nw_q both low: write takes precedence; db_oe=0.
  - Multiple W# pulses within one selection: only the first commits.
  - Address change while still selected: the latched idx is used until IDLE.
  - Back-to-back accesses need at least one deselected sampled cycle; an unbroken selection is one access.
  - nw low while in WAIT: ignored; the commit happens in ACK if nw_q is still low.
  - Reset mid-access: immediate return to reset values; the partial write is lost.
  - WAIT_CYCLES=0: nws never goes low.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=2'd0, WAIT=2'd1, ACK=2'd2).
  - Bus strobe polarity constants (ASSERTED=1'b0).
  - Default wait-count width (4).
- One natural sub-module: dbus_wait_counter (load / decrement / zero flag, async reset). The register bank stays inline.

Test Plan:
- Reset: hold reset=1 mid-WAIT -> nws=1, db_oe=0, all regs=0, state IDLE, immediately and asynchronously.
- IO write, WAIT_CYCLES=2:
  - Stimulus: nio=0, ab=16'h0012, then nw=0 with db_in=16'hBEEF.
  - Required: nws low exactly 2 cycles; single wr_strobe with wr_index=2; regs[2]=16'hBEEF.
- Read back: nio=0, ab=16'h0012, nr=0 -> after the wait, db_oe=1 and db_out=16'hBEEF; db_oe=0 one edge after nio_q returns high.
- Decode miss:
  - ab=16'h0014 or nmem=0 with IO_SPACE=1 -> nws stays 1, db_oe=0, no wr_strobe.
  - ab=16'h0013 -> hit, idx=3.
- Abort and duplicates:
  - nio released during WAIT -> return to IDLE, no write.
  - Two W# pulses in one selection with 16'h1111 then 16'h2222 -> reg holds 16'h1111, one wr_strobe.
- Conflict and zero wait:
  - nr=0 and nw=0 together -> write committed, db_oe=0.
  - With WAIT_CYCLES=0, nws never asserts and a read drives on the second edge after selection.
